// File: rtl/evt_rate_meter_pkg.sv
// evt_rate_meter_pkg: shared FSM type and sizing helper for the event rate meter
package evt_rate_meter_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: per-channel event counter that pins at all-ones and flags lost increments
module sat_counter
    import evt_rate_meter_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [COUNT_W-1:0] count,
    output logic               sat
);
    // Count up on inc; once all-ones, hold and remember that an event was dropped
    always_ff @(posedge clk)
        if (rst || clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc) begin
            if (&count) sat <= 1'b1;
            else count <= count + COUNT_W'(1);
        end
endmodule

// File: rtl/evt_rate_meter.sv
// evt_rate_meter: windowed multi-channel event counter with snapshot drained over valid/ready
module evt_rate_meter
    import evt_rate_meter_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int COUNT_W  = 16,
    parameter int WINDOW_W = 24,
    localparam int CW      = ch_w(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clear,
    input  logic [WINDOW_W-1:0] window_len,
    input  logic [NUM_CH-1:0]   evt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CW-1:0]       out_ch,
    output logic [COUNT_W-1:0]  out_count,
    output logic                out_sat,
    output logic                out_last,
    output logic                overrun
);
    logic [WINDOW_W-1:0]             timer, len_q;
    logic                            term, snap, load, last_hs, ovr_set;
    logic [NUM_CH-1:0][COUNT_W-1:0]  cnt, cnt_in, sh_cnt;
    logic [NUM_CH-1:0]               sat, sat_in, sh_sat;
    state_t                          state, state_d;
    logic [CW-1:0]                   ch_d;

    assign term = en && (len_q != '0) && (timer == len_q - WINDOW_W'(1));
    assign snap = term && !clear;

    // Window timer: runs while enabled, restarts with a freshly sampled length at each window start
    always_ff @(posedge clk)
        if (rst || clear || term) begin
            timer <= '0;
            len_q <= window_len;
        end else if (en) timer <= timer + WINDOW_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sat_counter #(.COUNT_W(COUNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (clear || term),
            .inc   (en && evt[i]),
            .count (cnt[i]),
            .sat   (sat[i])
        );
        assign cnt_in[i] = (en && evt[i] && !(&cnt[i])) ? cnt[i] + COUNT_W'(1) : cnt[i];
        assign sat_in[i] = sat[i] || (en && evt[i] && (&cnt[i]));
    end

    // Snapshot every channel together, folding in any event on the terminal cycle
    always_ff @(posedge clk)
        if (rst) begin
            sh_cnt <= '0;
            sh_sat <= '0;
        end else if (load) begin
            sh_cnt <= cnt_in;
            sh_sat <= sat_in;
        end

    // Drain state, channel pointer and sticky overrun flag
    always_ff @(posedge clk)
        if (rst) begin
            state   <= IDLE;
            out_ch  <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_d;
            out_ch  <= ch_d;
            overrun <= overrun || ovr_set;
        end

    // Advance on each accepted word; a snapshot is taken only when the drain is idle or just finishing
    always_comb begin
        last_hs = (state == SEND) && out_ready && (out_ch == CW'(NUM_CH - 1));
        load    = snap && ((state == IDLE) || last_hs);
        ovr_set = snap && !load;
        state_d = load ? SEND : last_hs ? IDLE : state;
        ch_d    = (load || last_hs) ? '0 :
                  ((state == SEND) && out_ready) ? out_ch + CW'(1) : out_ch;
    end

    assign out_valid = (state == SEND);
    assign out_count = sh_cnt[out_ch];
    assign out_sat   = sh_sat[out_ch];
    assign out_last  = out_valid && (out_ch == CW'(NUM_CH - 1));
endmodule

// File: tb/tb_evt_rate_meter.sv
// tb_evt_rate_meter: directed stimulus checked each cycle against a queue-based window model
module tb_evt_rate_meter;
    localparam int NCH  = 4;
    localparam int CWID = 4;
    localparam int WW   = 8;
    localparam int MAXC = (1 << CWID) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b1;
    logic            clear = 1'b0;
    logic            out_ready = 1'b1;
    logic [WW-1:0]   window_len = '0;
    logic [NCH-1:0]  evt = '0;
    logic            out_valid, out_sat, out_last, overrun;
    logic [1:0]      out_ch;
    logic [CWID-1:0] out_count;

    int checks = 0;
    int errors = 0;

    typedef struct {int ch; int cnt; int sat; int last;} word_t;
    word_t q[$];
    int    n[NCH];
    int    pos, len;
    bit    ovr;

    evt_rate_meter #(.NUM_CH(NCH), .COUNT_W(CWID), .WINDOW_W(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clear      (clear),
        .window_len (window_len),
        .evt        (evt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_count  (out_count),
        .out_sat    (out_sat),
        .out_last   (out_last),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Window model: raw event totals per channel, a queue of words still owed downstream
    task automatic model_step();
        bit term;
        if (rst) begin
            foreach (n[i]) n[i] = 0;
            pos = 0;
            len = window_len;
            q.delete();
            ovr = 0;
            return;
        end
        term = en && len != 0 && pos == len - 1;
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (en) foreach (n[i]) n[i] += evt[i];
        if (term && !clear) begin
            if (q.size() == 0)
                foreach (n[i]) q.push_back('{i, (n[i] > MAXC) ? MAXC : n[i], n[i] > MAXC, i == NCH - 1});
            else ovr = 1;
        end
        if (clear || term) begin
            foreach (n[i]) n[i] = 0;
            pos = 0;
            len = window_len;
        end else if (en) pos++;
    endtask

    task automatic compare_all();
        chk("valid", out_valid, q.size() > 0);
        chk("overrun", overrun, ovr);
        if (q.size() > 0) begin
            chk("ch", out_ch, q[0].ch);
            chk("count", out_count, q[0].cnt);
            chk("sat", out_sat, q[0].sat);
            chk("last", out_last, q[0].last);
        end else chk("last_idle", out_last, 0);
    endtask

    task automatic cyc(input logic [NCH-1:0] e, input logic c, input logic r);
        evt = e;
        clear = c;
        out_ready = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic hand(input string nm, input int ch, input int cnt, input int s, input int last);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_ch"}, out_ch, ch);
        chk({nm, "_count"}, out_count, cnt);
        chk({nm, "_sat"}, out_sat, s);
        chk({nm, "_last"}, out_last, last);
    endtask

    task automatic do_rst(input int wl);
        rst = 1'b1;
        en = 1'b1;
        window_len = WW'(wl);
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        do_rst(10);
        chk("rst_ch", out_ch, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ovr", overrun, 0);

        for (int c = 0; c < 16; c++) begin
            cyc({1'b0, c inside {0, 2, 4, 6, 8}, 1'b0, c inside {1, 3, 5}}, 1'b0, 1'b1);
            if (c == 8)  chk("t1_early", out_valid, 0);
            if (c == 9)  hand("t1_w0", 0, 3, 0, 0);
            if (c == 10) hand("t1_w1", 1, 0, 0, 0);
            if (c == 11) hand("t1_w2", 2, 5, 0, 0);
            if (c == 12) hand("t1_w3", 3, 0, 0, 1);
            if (c == 13) chk("t1_done", out_valid, 0);
        end

        do_rst(32);
        for (int c = 0; c < 70; c++) begin
            cyc({2'b00, c < 20 || c == 40 || c == 50, 1'b0}, 1'b0, 1'b1);
            if (c == 32) hand("t2_sat", 1, 15, 1, 0);
            if (c == 64) hand("t2_next", 1, 2, 0, 0);
        end

        do_rst(8);
        for (int c = 0; c < 20; c++) begin
            cyc({3'b000, c == 7}, 1'b0, 1'b1);
            if (c == 7)  hand("t3_term", 0, 1, 0, 0);
            if (c == 15) hand("t3_next", 0, 0, 0, 0);
        end

        do_rst(6);
        for (int c = 0; c < 30; c++) begin
            cyc((c < 6) ? 4'(c) : 4'b0000, 1'b0, c % 3 == 2);
            if (c == 5) hand("t4_w0", 0, 3, 0, 0);
            if (c == 7) hand("t4_hold", 0, 3, 0, 0);
            if (c == 11) begin
                hand("t4_ovr", 2, 2, 0, 0);
                chk("t4_ovr_flag", overrun, 1);
            end
            if (c == 17) hand("t4_reload", 0, 0, 0, 0);
        end

        do_rst(10);
        for (int c = 0; c < 40; c++) begin
            en = !(c == 6 || c == 7);
            cyc({3'b000, c inside {0, 1, 2, 3, 5, 6}}, c == 3 || c == 25, 1'b1);
            if (c == 13) chk("t5_none", out_valid, 0);
            if (c == 15) hand("t5_w0", 0, 1, 0, 0);
            if (c == 25) chk("t5_clr_term", out_valid, 0);
            if (c == 35) hand("t5_after", 0, 0, 0, 0);
        end
        en = 1'b1;

        do_rst(2);
        for (int c = 0; c < 50; c++) begin
            rst = (c == 4);
            if (c == 4) window_len = '0;
            cyc((c < 4) ? 4'b1111 : 4'b0101, 1'b0, 1'b1);
            if (c == 3) begin
                hand("t6_ch2", 2, 2, 0, 0);
                chk("t6_ovr_set", overrun, 1);
            end
            if (c == 4) begin
                chk("t6_rst_valid", out_valid, 0);
                chk("t6_rst_ovr", overrun, 0);
            end
        end
        rst = 1'b0;
        chk("t6_off", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/evt_rate_meter.md
Name: evt_rate_meter

Overview:
Multi-channel, windowed event counter for the audio-reactive lighting pipeline. One saturating counter per channel counts event pulses (e.g. beat or onset strobes per band) over a programmable window of clock cycles. At window end all counts are snapshotted together. The snapshot is then drained channel by channel over a valid/ready stream to the lighting mapper.

Parameters:
NUM_CH, 4, number of independent event channels (>=1)
COUNT_W, 16, width of each per-channel count
WINDOW_W, 24, width of the window-length register (cycles)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
en  input  1  1 = counting and window timer run; 0 = both freeze
clear  input  1  synchronous clear of live counters and window timer
window_len  input  WINDOW_W  window length in cycles; sampled at each window start
evt  input  NUM_CH  per-channel single-cycle event strobes
out_valid  output  1  snapshot word available
out_ready  input  1  downstream accepts word
out_ch  output  $clog2(NUM_CH) (min 1)  channel index of current word
out_count  output  COUNT_W  snapshotted count for out_ch
out_sat  output  1  count for out_ch saturated during its window
out_last  output  1  high with the word for channel NUM_CH-1
overrun  output  1  sticky; a window closed while the previous snapshot was still draining

Behaviour:
- Reset: live counters, sat bits, timer, shadow regs = 0; out_valid, out_last, overrun = 0; out_ch = 0; FSM = IDLE. Reset mid-drain aborts the drain; out_valid is low the cycle after rst.
- Window timer: the active length L is latched from window_len at reset release and at every window restart. The timer counts 0..L-1 while en=1. The terminal cycle is timer==L-1 with en=1. L==0 means windowing is disabled: no snapshots occur, but counters still count.
- Live counters: +1 on evt[i] when en=1. At 2^COUNT_W-1 the counter holds and sets sat[i].
- Terminal cycle: an event on the terminal cycle belongs to the closing window. The snapshot is the counter value including that event. On the next cycle, live counters and sat bits restart at 0, and the timer restarts at 0 with a freshly latched L.
- clear: the next cycle has counters, sat and timer = 0, with no snapshot. clear wins over evt and over the terminal cycle. clear does not affect the shadow regs, the drain or overrun.
- en=0: counters and timer hold, and evt is ignored. The drain continues independently of en.
- FSM:
  - IDLE: on snapshot, load shadow regs, go to SEND, set out_ch=0.
  - SEND: out_valid=1. out_ch, out_count and out_sat are stable while valid && !ready. On valid && ready: if out_ch==NUM_CH-1, go to IDLE (out_valid=0 next cycle), else out_ch+1.
- Latency: the first word is valid 1 cycle after the terminal cycle. With out_ready tied high, the drain takes NUM_CH cycles.
- Overrun: a terminal cycle while in SEND sets overrun (sticky until rst). That snapshot is discarded and the in-progress drain is unaffected. A terminal cycle on the same cycle as the final handshake is not an overrun: the FSM reloads and goes directly to SEND.
- out_valid never depends combinationally on out_ready.

Decomposition:
- Package evt_rate_meter_pkg holds the FSM state enum (IDLE, SEND) and a localparam function for the channel-index width (max(1,$clog2(NUM_CH))).
- One sub-module, sat_counter (COUNT_W; inputs clk, rst, clr, inc; outputs count, sat), is instantiated NUM_CH times in a generate loop.

Test Plan:
1. NUM_CH=4, window_len=10, out_ready=1, evt[0] pulsed 3x, evt[2] 5x in window 1 -> 4 words: (0,3),(1,0),(2,5),(3,0), out_last on ch3, first word valid 1 cycle after cycle 9.
2. COUNT_W=4, evt[1] high for 20 cycles of a 32-cycle window -> ch1 word has out_count=15 and out_sat=1; next window starts at 0 with sat=0.
3. evt[0] on terminal cycle only, window_len=8 -> count=1 in closing window and 0 in the next window.
4. out_ready toggled 1-in-3 on backpressure -> word data stable while stalled. window_len=6 < drain time -> overrun=1, the old snapshot drains intact, and no extra words are emitted.
5. clear asserted mid-window with evt coincident -> counts and timer are 0 the next cycle. A clear on the terminal cycle produces no snapshot.
6. rst asserted during SEND at ch2 -> out_valid=0, overrun=0, counts=0 the next cycle. window_len=0 -> no out_valid ever.
